// File: rtl/hb_frame_packer.sv
// rtl/hb_frame_packer.sv - buffers decimator samples and serializes them into checksummed byte frames
module hb_frame_packer #(
    parameter int         DATA_W     = 64,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] HDR0       = 8'hAA,
    parameter logic [7:0] HDR1       = 8'h55
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [DATA_W-1:0]             pi_data,
    input  logic                          pi_flag,
    output logic [7:0]                    tx_byte,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [7:0]                    seq_num
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int NB  = DATA_W / 8;
    localparam int NFB = NB + 4;
    localparam int IW  = $clog2(NFB);
    localparam logic [AW:0]   DEPTH_C    = (AW+1)'(FIFO_DEPTH);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NFB - 1);
    localparam logic [IW-1:0] IDX_LASTD  = IW'(NB + 1);

    typedef enum logic {IDLE, SEND} state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q;

    state_t            state_q;
    logic [DATA_W-1:0] frame_q;
    logic [IW-1:0]     idx_q;
    logic [7:0]        chk_q, seq_q, tx_byte_q;
    logic              tx_valid_q;

    logic empty, full, xfer, last, pop, push;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign xfer  = tx_valid_q && tx_ready;
    assign last  = (idx_q == IDX_LAST);
    // The head is popped either to start a frame from idle or to chain directly after a checksum byte.
    assign pop   = !empty && ((state_q == IDLE) || (xfer && last));
    assign push  = pi_flag && (!full || pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= pi_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (pi_flag && !push) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            idx_q      <= '0;
            chk_q      <= '0;
            seq_q      <= '0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        frame_q    <= mem_q[rd_ptr_q];
                        idx_q      <= '0;
                        tx_byte_q  <= HDR0;
                        tx_valid_q <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        idx_q <= idx_q + 1'b1;
                        if (last) begin
                            seq_q <= seq_q + 1'b1;
                            if (pop) begin
                                frame_q   <= mem_q[rd_ptr_q];
                                idx_q     <= '0;
                                tx_byte_q <= HDR0;
                            end else begin
                                tx_valid_q <= 1'b0;
                                tx_byte_q  <= '0;
                                state_q    <= IDLE;
                            end
                        end else if (idx_q == IW'(0)) begin
                            tx_byte_q <= HDR1;
                        end else if (idx_q == IW'(1)) begin
                            tx_byte_q <= seq_q;
                            chk_q     <= seq_q;
                        end else if (idx_q <= IDX_LASTD) begin
                            // Data goes out MSB first by shifting the frame register left a byte at a time.
                            tx_byte_q <= frame_q[DATA_W-1 -: 8];
                            chk_q     <= chk_q + frame_q[DATA_W-1 -: 8];
                            frame_q   <= frame_q << 8;
                        end else begin
                            tx_byte_q <= chk_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_byte    = tx_byte_q;
    assign tx_valid   = tx_valid_q;
    assign fifo_level = count_q;
    assign overflow   = overflow_q;
    assign seq_num    = seq_q;
endmodule

// File: tb/tb_hb_frame_packer.sv
// tb/tb_hb_frame_packer.sv - scoreboard bench for hb_frame_packer framing, backpressure, overflow and reset
module tb_hb_frame_packer;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [63:0] pi_data = '0;
    logic        pi_flag = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [7:0]  seq_num;

    int          errors = 0;
    int          checks = 0;
    int          xfers  = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_seq = 8'h00;
    logic        stall_q = 1'b0;
    logic [7:0]  held_q = 8'h00;

    hb_frame_packer dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pi_data   (pi_data),
        .pi_flag   (pi_flag),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .seq_num   (seq_num)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [63:0] d);
        logic [7:0] chk;
        logic [7:0] b;
        chk = exp_seq;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(exp_seq);
        for (int k = 7; k >= 0; k--) begin
            b = d[k*8 +: 8];
            chk = chk + b;
            exp_q.push_back(b);
        end
        exp_q.push_back(chk);
        exp_seq = exp_seq + 8'd1;
    endtask

    // Monitor: every accepted byte is popped from the scoreboard; stalled bytes must hold.
    always @(negedge sys_clk) begin
        if (tx_valid && stall_q) check("stall_hold", tx_byte, held_q);
        if (tx_valid && tx_ready) begin
            xfers++;
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 1, 0);
            end else begin
                check("byte", tx_byte, exp_q.pop_front());
            end
        end
        stall_q = tx_valid && !tx_ready;
        held_q  = tx_byte;
    end

    task automatic burst(input logic [63:0] s[$]);
        foreach (s[i]) begin
            @(posedge sys_clk); #1;
            pi_flag = 1'b1;
            pi_data = s[i];
        end
        @(posedge sys_clk); #1;
        pi_flag = 1'b0;
    endtask

    task automatic push1(input logic [63:0] d);
        logic [63:0] s[$];
        s.push_back(d);
        burst(s);
    endtask

    task automatic wait_idle(input int max, input bit bp);
        int c = 0;
        while (exp_q.size() != 0 || tx_valid) begin
            if (c >= max) begin
                check("drain_timeout", c, max);
                return;
            end
            @(posedge sys_clk); #1;
            if (bp) tx_ready = (c % 3 == 0);
            c++;
        end
    endtask

    task automatic do_reset();
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b0;
        exp_q.delete();
        exp_seq = 8'h00;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] s[$];
        int base;
        int c;

        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_seq_num", seq_num, 0);
        sys_rst_n = 1'b1;

        // Single sample with two-cycle latency.
        tx_ready = 1'b1;
        expect_frame(64'h0123456789ABCDEF);
        push1(64'h0123456789ABCDEF);
        check("lat_t1_valid", tx_valid, 0);
        @(posedge sys_clk); #1;
        check("lat_t2_valid", tx_valid, 1);
        check("lat_t2_hdr0", tx_byte, 8'hAA);
        wait_idle(100, 1'b0);
        check("single_seq_num", seq_num, 1);
        check("single_tx_valid", tx_valid, 0);
        check("single_level", fifo_level, 0);

        // Backpressure: ready pattern 1,0,0 repeating.
        do_reset();
        base = xfers;
        expect_frame(64'h0123456789ABCDEF);
        push1(64'h0123456789ABCDEF);
        wait_idle(200, 1'b1);
        check("bp_xfer_count", xfers - base, 12);

        // All-ones sample at seq 0 gives checksum F8.
        do_reset();
        tx_ready = 1'b1;
        expect_frame(64'hFFFFFFFFFFFFFFFF);
        push1(64'hFFFFFFFFFFFFFFFF);
        wait_idle(100, 1'b0);

        // Overflow: six back-to-back samples under full backpressure.
        do_reset();
        tx_ready = 1'b0;
        s.delete();
        for (int i = 1; i <= 6; i++) s.push_back({8{8'(i * 8'h11)}});
        for (int i = 0; i < 5; i++) expect_frame(s[i]);
        burst(s);
        @(posedge sys_clk); #1;
        check("ovf_level", fifo_level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_valid_hdr", {tx_valid, tx_byte}, {1'b1, 8'hAA});
        base = xfers;
        tx_ready = 1'b1;
        repeat (60) @(negedge sys_clk);
        #1;
        check("ovf_no_gap", xfers - base, 60);
        @(posedge sys_clk); #1;
        check("ovf_end_valid", tx_valid, 0);
        check("ovf_sticky", overflow, 1);
        check("ovf_seq_num", seq_num, 5);

        // Sequence wrap across 257 frames.
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            expect_frame({32'hA5C3_0000 | 32'(i), 32'(i) * 32'h01010101});
            push1({32'hA5C3_0000 | 32'(i), 32'(i) * 32'h01010101});
            wait_idle(100, 1'b0);
            if (i == 255) check("wrap_seq_zero", seq_num, 0);
        end
        check("wrap_seq_one", seq_num, 1);

        // Reset after byte 5 of a frame.
        do_reset();
        tx_ready = 1'b1;
        s.delete();
        for (int i = 0; i < 6; i++) s.push_back(64'h1);
        tx_ready = 1'b0;
        burst(s);
        tx_ready = 1'b1;
        base = xfers;
        expect_frame(64'h1);
        c = 0;
        while (xfers < base + 6 && c < 50) begin
            @(posedge sys_clk); #2;
            c++;
        end
        check("mid_reached_byte5", xfers - base, 6);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", tx_valid, 0);
        exp_q.delete();
        exp_seq = 8'h00;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        check("mid_seq_num", seq_num, 0);
        check("mid_level", fifo_level, 0);
        check("mid_overflow", overflow, 0);
        expect_frame(64'hDEADBEEFCAFEF00D);
        push1(64'hDEADBEEFCAFEF00D);
        wait_idle(100, 1'b0);
        check("mid_seq_after", seq_num, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
